vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates the 800x600@60 Hz VGA raster timing for the display pipeline. It runs from the 40 MHz pixel clock and produces the pixel/line counters plus blanking and sync strobes. The map-drawing stage and any later overlay stages consume these outputs; the sync strobes are forwarded, delay-matched, to the VGA connector. It also provides a once-per-frame tick and a frame counter so that game logic can update during vertical blanking.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FRONT, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BACK, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
V_VISIBLE, 600, visible lines per frame
V_FRONT, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BACK, 23, vertical back porch (lines); V_TOTAL = sum = 628
SYNC_POS, 1, 1 = sync strobes active-high, 0 = active-low

Ports:
clk  input  1  pixel clock, 40 MHz
rst  input  1  asynchronous reset, active-low (0 = reset)
hcount  output  11  pixel index in line, 0..H_TOTAL-1
vcount  output  10  line index in frame, 0..V_TOTAL-1
hblnk  output  1  high while hcount >= H_VISIBLE
vblnk  output  1  high while vcount >= V_VISIBLE
hsync  output  1  active (per SYNC_POS) while H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC
vsync  output  1  active (per SYNC_POS) while V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC
frame_tick  output  1  one-cycle pulse when (hcount,vcount) = (0,V_VISIBLE)
frame_cnt  output  16  count of completed visible frames, wraps at 65535 -> 0

Behaviour:
- All outputs are registered. They always describe the same (hcount,vcount) position in the same cycle, with no skew between counters and strobes. Strobes are computed from the next-state counter values and registered alongside the counters.
- Reset (rst=0, asynchronous, takes effect immediately without a clock edge): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=vsync=inactive level (~SYNC_POS), frame_tick=0, frame_cnt=0.
- First rising edge with rst=1: position advances to (1,0). Position (0,0) is therefore presented during reset and counts as the first pixel.
- Horizontal counter: increments every cycle. At H_TOTAL-1 it wraps to 0 and vcount advances by one.
- Vertical counter: advances only on horizontal wrap. At (H_TOTAL-1, V_TOTAL-1) both counters wrap to (0,0).
- Frame period: exactly H_TOTAL*V_TOTAL = 663168 cycles. There are no dropped or extra cycles across wraps.
- frame_tick: high for exactly one cycle per frame, in the cycle where the outputs show hcount=0, vcount=V_VISIBLE (first pixel of vertical blanking).
- frame_cnt: increments in the same cycle that frame_tick is asserted. It holds at all other times. It wraps 65535 -> 0 with no flag.
- hblnk and vblnk are independent. Downstream stages treat (hblnk|vblnk) as blank.
- Reset asserted mid-frame: all outputs return to reset values immediately. After release, counting restarts from (0,0) with no partial-frame tick.
- Counter widths: hcount 11 bits (max 1055), vcount 10 bits (max 627). Out-of-range values never occur.
- No other inputs. The block free-runs whenever rst=1.

Test Plan:
- Reset check: hold rst=0 and toggle clk -> hcount=0, vcount=0, hblnk=vblnk=0, hsync=vsync=0 (SYNC_POS=1), frame_cnt=0. Release rst -> next edge shows hcount=1.
- Line wrap: run to hcount=1055, vcount=0 -> next cycle hcount=0, vcount=1. hblnk high for hcount 800..1055 (256 cycles/line). hsync high for hcount 840..967 (exactly 128 cycles).
- Frame wrap and vertical strobes: vblnk rises with vcount=600 at hcount=0. vsync high for vcount 601..604 (4*1056 = 4224 cycles). (1055,627) -> (0,0).
- Frame timing: measure the interval between consecutive frame_tick pulses -> 663168 cycles. Each pulse is 1 cycle wide at (0,600). frame_cnt increments 0 -> 1 -> 2 with the pulses.
- Asynchronous reset mid-frame: pull rst low at (400,300) between clock edges -> outputs go to reset values before the next edge. After release there is no frame_tick until (0,600) of the new frame.
- Polarity: SYNC_POS=0 -> hsync/vsync idle high and pulse low over the same windows. The reset value of both is 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator (default 800x600@60 Hz, 40 MHz
//               pixel clock). Produces pixel/line counters, blanking and
//               sync strobes, a once-per-frame tick at the first line of
//               vertical blanking, and a count of completed visible frames.
//
// Ports:
//   clk        in   1   pixel clock
//   rst        in   1   asynchronous reset, active-low (0 = reset)
//   hcount     out  11  pixel index in line, 0..H_TOTAL-1
//   vcount     out  10  line index in frame, 0..V_TOTAL-1
//   hblnk      out  1   high while hcount >= H_VISIBLE
//   vblnk      out  1   high while vcount >= V_VISIBLE
//   hsync      out  1   horizontal sync, polarity set by SYNC_POS
//   vsync      out  1   vertical sync, polarity set by SYNC_POS
//   frame_tick out  1   one-cycle pulse at (hcount,vcount) = (0,V_VISIBLE)
//   frame_cnt  out  16  completed visible frames, wraps 65535 -> 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int SYNC_POS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    // ------------------------------------------------------------------------
    // Derived timing constants, pre-sized to the counter widths so every
    // comparison below is width-matched.
    // ------------------------------------------------------------------------
    localparam int          c_h_total  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_v_total  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] c_h_last   = 11'(c_h_total - 1);
    localparam logic [10:0] c_h_vis    = 11'(H_VISIBLE);
    localparam logic [10:0] c_hs_start = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_hs_end   = 11'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0]  c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0]  c_v_vis    = 10'(V_VISIBLE);
    localparam logic [9:0]  c_vs_start = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  c_vs_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Active and idle levels of the sync strobes.
    localparam logic        c_sync_on  = (SYNC_POS != 0);
    localparam logic        c_sync_off = ~c_sync_on;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [10:0] hcount_q,     hcount_d;
    logic [9:0]  vcount_q,     vcount_d;
    logic        hblnk_q,      hblnk_d;
    logic        vblnk_q,      vblnk_d;
    logic        hsync_q,      hsync_d;
    logic        vsync_q,      vsync_d;
    logic        frame_tick_q, frame_tick_d;
    logic [15:0] frame_cnt_q,  frame_cnt_d;

    logic        w_h_last;
    logic        w_v_last;

    // ------------------------------------------------------------------------
    // Next-state logic. The strobes are decoded from the *next* counter
    // values so that, once registered, every output describes the same
    // raster position as hcount/vcount in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_h_last     = (hcount_q == c_h_last);
        w_v_last     = (vcount_q == c_v_last);

        hcount_d     = hcount_q + 11'd1;
        vcount_d     = vcount_q;
        frame_cnt_d  = frame_cnt_q;

        if (w_h_last) begin
            hcount_d = 11'd0;
            vcount_d = w_v_last ? 10'd0 : (vcount_q + 10'd1);
        end

        hblnk_d      = (hcount_d >= c_h_vis);
        vblnk_d      = (vcount_d >= c_v_vis);

        hsync_d      = ((hcount_d >= c_hs_start) && (hcount_d < c_hs_end))
                       ? c_sync_on : c_sync_off;
        vsync_d      = ((vcount_d >= c_vs_start) && (vcount_d < c_vs_end))
                       ? c_sync_on : c_sync_off;

        // First pixel of vertical blanking marks the end of a visible frame.
        frame_tick_d = (hcount_d == 11'd0) && (vcount_d == c_v_vis);

        if (frame_tick_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Reset presents position (0,0) with strobes idle, so the
    // first rising edge after release moves to (1,0).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q     <= 11'd0;
            vcount_q     <= 10'd0;
            hblnk_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            hsync_q      <= c_sync_off;
            vsync_q      <= c_sync_off;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hblnk_q      <= hblnk_d;
            vblnk_q      <= vblnk_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign hblnk      = hblnk_q;
    assign vblnk      = vblnk_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed self-checking bench for vga_timing_gen. A full-size
//               instance covers reset and line timing; two reduced-geometry
//               instances (16x12 total, active-high and active-low sync)
//               cover frame-level timing in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Full-size instance (default 800x600 timing, active-high sync)
    logic [10:0] f_hc;
    logic [9:0]  f_vc;
    logic        f_hblnk, f_vblnk, f_hsync, f_vsync, f_tick;
    logic [15:0] f_fc;

    // Reduced instance: H 8+2+3+3 = 16, V 6+1+2+3 = 12, frame = 192 cycles
    logic [10:0] s_hc;
    logic [9:0]  s_vc;
    logic        s_hblnk, s_vblnk, s_hsync, s_vsync, s_tick;
    logic [15:0] s_fc;

    // Reduced instance with active-low sync
    logic [10:0] n_hc;
    logic [9:0]  n_vc;
    logic        n_hblnk, n_vblnk, n_hsync, n_vsync, n_tick;
    logic [15:0] n_fc;

    vga_timing_gen u_full (
        .clk        (clk),
        .rst        (rst),
        .hcount     (f_hc),
        .vcount     (f_vc),
        .hblnk      (f_hblnk),
        .vblnk      (f_vblnk),
        .hsync      (f_hsync),
        .vsync      (f_vsync),
        .frame_tick (f_tick),
        .frame_cnt  (f_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
        .SYNC_POS  (1)
    ) u_small (
        .clk        (clk),
        .rst        (rst),
        .hcount     (s_hc),
        .vcount     (s_vc),
        .hblnk      (s_hblnk),
        .vblnk      (s_vblnk),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .frame_tick (s_tick),
        .frame_cnt  (s_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
        .SYNC_POS  (0)
    ) u_neg (
        .clk        (clk),
        .rst        (rst),
        .hcount     (n_hc),
        .vcount     (n_vc),
        .hblnk      (n_hblnk),
        .vblnk      (n_vblnk),
        .hsync      (n_hsync),
        .vsync      (n_vsync),
        .frame_tick (n_tick),
        .frame_cnt  (n_fc)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line-walk bookkeeping (full instance)
    int line_hblnk = 0, line_hsync = 0, line_vblnk = 0;
    int hs_first = -1, hs_last = -1, vc_at_end = -1;

    // Frame-walk bookkeeping (reduced instances)
    int t1 = -1, t2 = -1, nt = 0;
    int tick_h = -1, tick_v = -1, fc1 = -1, fc2 = -1, fc_pre = -1;
    int nvb = 0, nvs = 0, nvs_neg = 0, vs_first = -1, vs_last = -1;
    int nhs = 0, nhb = 0, nhs_neg = 0;
    int w_h = -1, w_v = -1, a_h = -1, a_v = -1;

    initial begin
        // ---------------- Reset held over several edges ----------------
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hcount",    f_hc,    0);
        chk("rst_vcount",    f_vc,    0);
        chk("rst_hblnk",     f_hblnk, 0);
        chk("rst_vblnk",     f_vblnk, 0);
        chk("rst_hsync",     f_hsync, 0);
        chk("rst_vsync",     f_vsync, 0);
        chk("rst_tick",      f_tick,  0);
        chk("rst_frame_cnt", f_fc,    0);
        chk("rst_neg_hsync", n_hsync, 1);
        chk("rst_neg_vsync", n_vsync, 1);

        // Release; the first rising edge moves to (1,0)
        rst = 1'b1;
        @(negedge clk);
        chk("first_hcount", f_hc, 1);
        chk("first_vcount", f_vc, 0);

        // ---------------- One full line on the 800x600 instance ----------------
        // Samples cover hcount 1..1055 of line 0; loop ends at (0,1).
        for (int i = 0; i < 1055; i++) begin
            if (f_hblnk) line_hblnk++;
            if (f_vblnk) line_vblnk++;
            if (f_hsync) begin
                line_hsync++;
                if (hs_first < 0) hs_first = int'(f_hc);
                hs_last = int'(f_hc);
            end
            if (f_hc == 11'd1055) vc_at_end = int'(f_vc);
            @(negedge clk);
        end
        chk("line_hblnk_cycles", line_hblnk, 256);
        chk("line_hsync_cycles", line_hsync, 128);
        chk("line_hsync_first",  hs_first,   840);
        chk("line_hsync_last",   hs_last,    967);
        chk("line_vblnk_cycles", line_vblnk, 0);
        chk("line_vc_at_1055",   vc_at_end,  0);
        chk("wrap_hcount",       f_hc,       0);
        chk("wrap_vcount",       f_vc,       1);

        // ---------------- Asynchronous reset between edges ----------------
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_full_hcount", f_hc,    0);
        chk("arst_full_vcount", f_vc,    0);
        chk("arst_small_vcount", s_vc,   0);
        chk("arst_small_fcnt",  s_fc,    0);
        chk("arst_small_hblnk", s_hblnk, 0);
        chk("arst_neg_hsync",   n_hsync, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- Frame walk on reduced instances ----------------
        // Sample n sits at raster index n mod 192 (index = v*16 + h).
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (s_tick) begin
                nt++;
                if (t1 < 0) begin
                    t1 = n; tick_h = int'(s_hc); tick_v = int'(s_vc); fc1 = int'(s_fc);
                end else if (t2 < 0) begin
                    t2 = n; fc2 = int'(s_fc);
                end
            end
            if (n == 95) fc_pre = int'(s_fc);
            if (n <= 192) begin
                if (s_vblnk) nvb++;
                if (!n_vsync) nvs_neg++;
                if (s_vsync) begin
                    nvs++;
                    if (vs_first < 0) vs_first = int'(s_vc);
                    vs_last = int'(s_vc);
                end
            end
            if (n <= 16) begin
                if (s_hsync)  nhs++;
                if (s_hblnk)  nhb++;
                if (!n_hsync) nhs_neg++;
            end
            if (n == 191) begin w_h = int'(s_hc); w_v = int'(s_vc); end
            if (n == 192) begin a_h = int'(s_hc); a_v = int'(s_vc); end
        end
        chk("small_first_tick_cycle", t1,      96);
        chk("small_tick_h",           tick_h,  0);
        chk("small_tick_v",           tick_v,  6);
        chk("small_tick_interval",    t2 - t1, 192);
        chk("small_tick_pulses",      nt,      2);
        chk("small_fcnt_before",      fc_pre,  0);
        chk("small_fcnt_tick1",       fc1,     1);
        chk("small_fcnt_tick2",       fc2,     2);
        chk("small_vblnk_cycles",     nvb,     96);
        chk("small_vsync_cycles",     nvs,     32);
        chk("small_vsync_first_line", vs_first, 7);
        chk("small_vsync_last_line",  vs_last, 8);
        chk("small_hsync_cycles",     nhs,     3);
        chk("small_hblnk_cycles",     nhb,     8);
        chk("neg_vsync_low_cycles",   nvs_neg, 32);
        chk("neg_hsync_low_cycles",   nhs_neg, 3);
        chk("small_last_pos_h",       w_h,     15);
        chk("small_last_pos_v",       w_v,     11);
        chk("small_frame_wrap_h",     a_h,     0);
        chk("small_frame_wrap_v",     a_v,     0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
